// File: rtl/matrix_operand_feeder_pkg.sv
// Shared definitions for the matrix operand feeder: word width, FSM state
// encodings and the index-width helper used to size ports and counters.
package matrix_operand_feeder_pkg;

    localparam int word_width = 32;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // A one-entry range still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_operand_feeder_bank.sv
// N*N operand word store with a serial write port; the read mux presents
// either a full row or a full column selected by rd_idx_i.
module matrix_bank
    import matrix_operand_feeder_pkg::*;
#(
    parameter int number_of_elements = 4,
    parameter bit read_column        = 1'b0
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 we_i,
    input  logic [idx_width(number_of_elements*number_of_elements)-1:0] waddr_i,
    input  logic [word_width-1:0]                                wdata_i,
    input  logic [idx_width(number_of_elements)-1:0]             rd_idx_i,
    output logic [number_of_elements*word_width-1:0]             rd_data_o
);

    localparam int N  = number_of_elements;
    localparam int NN = N * N;
    localparam int AW = idx_width(NN);

    logic [word_width-1:0] mem_q [NN];
    logic [AW-1:0]         rd_addr_s [N];

    // Word storage, written one entry per enabled edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NN; e++) begin
                mem_q[e] <= {word_width{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Row mode gathers entries idx*N+k, column mode gathers k*N+idx.
    always_comb begin
        rd_data_o = {(N*word_width){1'b0}};
        for (int k = 0; k < N; k++) begin
            rd_addr_s[k] = {AW{1'b0}};
        end
        for (int k = 0; k < N; k++) begin
            if (read_column) begin
                rd_addr_s[k] = AW'(k * N + int'(rd_idx_i));
            end else begin
                rd_addr_s[k] = AW'(int'(rd_idx_i) * N + k);
            end
            rd_data_o[k*word_width +: word_width] = mem_q[rd_addr_s[k]];
        end
    end

endmodule

// File: rtl/matrix_operand_feeder.sv
// Loads matrices A and B serially, then presents every (row of A, column of B)
// pair in row-major order with independent row/column handshakes.
module matrix_operand_feeder
    import matrix_operand_feeder_pkg::*;
#(
    parameter int number_of_elements = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [word_width-1:0]                    in_data,
    input  logic                                     in_i_stb,
    output logic                                     in_i_ack,
    output logic [number_of_elements*word_width-1:0] row,
    output logic [number_of_elements*word_width-1:0] column,
    output logic                                     row_o_stb,
    output logic                                     column_o_stb,
    input  logic                                     row_o_ack,
    input  logic                                     column_o_ack,
    output logic [idx_width(number_of_elements)-1:0] row_idx,
    output logic [idx_width(number_of_elements)-1:0] col_idx,
    output logic                                     done
);

    localparam int N  = number_of_elements;
    localparam int NN = N * N;
    localparam int IW = idx_width(N);
    localparam int AW = idx_width(NN);
    localparam int CW = idx_width(2 * NN);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d;
    logic          in_ack_q, in_ack_d;
    logic          row_stb_q, row_stb_d;
    logic          col_stb_q, col_stb_d;
    logic          done_q, done_d;

    logic          xfer_s, last_word_s, load_b_s, a_we_s, b_we_s;
    logic          pair_done_s, last_pair_s;
    logic [AW-1:0] waddr_s;

    assign xfer_s      = (state_q == ST_LOAD) && in_i_stb && in_ack_q;
    assign last_word_s = (word_cnt_q == CW'(2 * NN - 1));
    assign load_b_s    = (word_cnt_q >= CW'(NN));
    assign a_we_s      = xfer_s && !load_b_s;
    assign b_we_s      = xfer_s && load_b_s;
    assign waddr_s     = load_b_s ? AW'(word_cnt_q - CW'(NN)) : AW'(word_cnt_q);

    // A side that already dropped its strobe counts as acknowledged.
    assign pair_done_s = (state_q == ST_ISSUE) && (!row_stb_q || row_o_ack) && (!col_stb_q || column_o_ack);
    assign last_pair_s = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

    matrix_bank #(
        .number_of_elements(N),
        .read_column       (1'b0)
    ) u_bank_a (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (a_we_s),
        .waddr_i  (waddr_s),
        .wdata_i  (in_data),
        .rd_idx_i (i_q),
        .rd_data_o(row)
    );

    matrix_bank #(
        .number_of_elements(N),
        .read_column       (1'b1)
    ) u_bank_b (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (b_we_s),
        .waddr_i  (waddr_s),
        .wdata_i  (in_data),
        .rd_idx_i (j_q),
        .rd_data_o(column)
    );

    // Next-state logic for the load / issue / advance / done sequence.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        in_ack_d   = 1'b0;
        row_stb_d  = row_stb_q;
        col_stb_d  = col_stb_q;
        done_d     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ack_d = 1'b1;
                if (xfer_s && last_word_s) begin
                    state_d    = ST_ISSUE;
                    word_cnt_d = {CW{1'b0}};
                    in_ack_d   = 1'b0;
                    row_stb_d  = 1'b1;
                    col_stb_d  = 1'b1;
                end else if (xfer_s) begin
                    word_cnt_d = word_cnt_q + CW'(1);
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            ST_ISSUE: begin
                row_stb_d = row_stb_q && !row_o_ack;
                col_stb_d = col_stb_q && !column_o_ack;
                if (pair_done_s && last_pair_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (pair_done_s) begin
                    state_d = ST_ADVANCE;
                    if (j_q == IW'(N - 1)) begin
                        j_d = {IW{1'b0}};
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ADVANCE: begin
                state_d   = ST_ISSUE;
                row_stb_d = 1'b1;
                col_stb_d = 1'b1;
            end
            ST_DONE: begin
                state_d    = ST_LOAD;
                in_ack_d   = 1'b1;
                word_cnt_d = {CW{1'b0}};
                i_d        = {IW{1'b0}};
                j_d        = {IW{1'b0}};
            end
            default: begin
                state_d    = ST_LOAD;
                word_cnt_d = {CW{1'b0}};
                i_d        = {IW{1'b0}};
                j_d        = {IW{1'b0}};
                row_stb_d  = 1'b0;
                col_stb_d  = 1'b0;
            end
        endcase
    end

    // State and handshake registers; every control output is driven from here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            word_cnt_q <= {CW{1'b0}};
            i_q        <= {IW{1'b0}};
            j_q        <= {IW{1'b0}};
            in_ack_q   <= 1'b0;
            row_stb_q  <= 1'b0;
            col_stb_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            in_ack_q   <= in_ack_d;
            row_stb_q  <= row_stb_d;
            col_stb_q  <= col_stb_d;
            done_q     <= done_d;
        end
    end

    assign in_i_ack     = in_ack_q;
    assign row_o_stb    = row_stb_q;
    assign column_o_stb = col_stb_q;
    assign row_idx      = i_q;
    assign col_idx      = j_q;
    assign done         = done_q;

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Bench for matrix_operand_feeder: an N=2 instance checked every cycle against
// a transaction-level model, plus a directed N=1 instance.
module tb_matrix_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data2, in_data1;
    logic        in_stb2, in_stb1, in_ack2, in_ack1;
    logic [63:0] row2, col2;
    logic [31:0] row1, col1;
    logic        rstb2, cstb2, rack2, cack2;
    logic        rstb1, cstb1, rack1, cack1;
    logic [0:0]  ridx2, cidx2, ridx1, cidx1;
    logic        done2, done1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    matrix_operand_feeder #(.number_of_elements(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_i_stb(in_stb2), .in_i_ack(in_ack2),
        .row(row2), .column(col2), .row_o_stb(rstb2), .column_o_stb(cstb2),
        .row_o_ack(rack2), .column_o_ack(cack2), .row_idx(ridx2), .col_idx(cidx2), .done(done2)
    );

    matrix_operand_feeder #(.number_of_elements(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_i_stb(in_stb1), .in_i_ack(in_ack1),
        .row(row1), .column(col1), .row_o_stb(rstb1), .column_o_stb(cstb1),
        .row_o_ack(rack1), .column_o_ack(cack1), .row_idx(ridx1), .col_idx(cidx1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model of the N=2 instance: words received, pair number p.
    localparam int PH_LOAD = 0, PH_ISSUE = 1, PH_GAP = 2, PH_DONE = 3;
    int          ph;
    bit          m_ack, m_rs, m_cs, m_done;
    int          m_cnt, m_p;
    logic [31:0] m_w [8];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= PH_LOAD; m_ack <= 1'b0; m_rs <= 1'b0; m_cs <= 1'b0;
            m_done <= 1'b0; m_cnt <= 0; m_p <= 0;
        end else begin
            case (ph)
                PH_LOAD: begin
                    if (!m_ack) begin
                        m_ack <= 1'b1;
                    end else if (in_stb2) begin
                        m_w[m_cnt] <= in_data2;
                        if (m_cnt == 7) begin
                            m_cnt <= 0; ph <= PH_ISSUE; m_ack <= 1'b0;
                            m_rs <= 1'b1; m_cs <= 1'b1; m_p <= 0;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
                PH_ISSUE: begin
                    m_rs <= m_rs && !rack2;
                    m_cs <= m_cs && !cack2;
                    if (!(m_rs && !rack2) && !(m_cs && !cack2)) begin
                        if (m_p == 3) begin
                            ph <= PH_DONE; m_done <= 1'b1;
                        end else begin
                            ph <= PH_GAP; m_p <= m_p + 1;
                        end
                    end
                end
                PH_GAP: begin
                    ph <= PH_ISSUE; m_rs <= 1'b1; m_cs <= 1'b1;
                end
                default: begin
                    ph <= PH_LOAD; m_done <= 1'b0; m_ack <= 1'b1; m_p <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of the N=2 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_i_ack", 64'(in_ack2), 64'(m_ack));
            check("row_o_stb", 64'(rstb2), 64'(m_rs));
            check("column_o_stb", 64'(cstb2), 64'(m_cs));
            check("done", 64'(done2), 64'(m_done));
            if (m_rs || m_cs) begin
                check("row_idx", 64'(ridx2), 64'(m_p / 2));
                check("col_idx", 64'(cidx2), 64'(m_p % 2));
                check("row", row2, {m_w[(m_p / 2) * 2 + 1], m_w[(m_p / 2) * 2]});
                check("column", col2, {m_w[6 + m_p % 2], m_w[4 + m_p % 2]});
            end
        end
    end

    task automatic load2(input logic [31:0] w [8], input int n, input bit rnd);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 300) begin
            @(negedge clk);
            guard++;
            rack2 = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            cack2 = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_stb2 = 1'b0; in_data2 = $urandom;
            end else begin
                in_stb2 = 1'b1; in_data2 = w[k];
                if (in_ack2) k++;
            end
        end
        check("load_words", 64'(k), 64'(n));
    endtask

    // mode 0: random acks, 1: both acks two cycles after strobe, 2: column early
    task automatic serve(input int mode, input bit lit);
        int cyc = 0, waitc = 0, ndone = 0, ngap = 0, tail = 0;
        bit prev_any = 1'b0, seen = 1'b0, any;
        logic [0:0] ri0 = 1'b0, ci0 = 1'b0;
        int seq[$];
        while (cyc < 500 && tail < 3) begin
            @(negedge clk);
            cyc++;
            if (ndone > 0) begin
                tail++;
                if (tail == 1) check("ack_after_done", 64'(in_ack2), 64'd1);
            end
            any = rstb2 | cstb2;
            if (any && !prev_any) begin
                waitc = 0; seen = 1'b1; ri0 = ridx2; ci0 = cidx2;
                seq.push_back(int'(ridx2) * 2 + int'(cidx2));
                if (lit && seq.size() == 1) begin
                    check("first_row", row2, 64'h40000000_3F800000);
                    check("first_column", col2, 64'h00000000_3F800000);
                end
            end else if (any) begin
                waitc++;
            end
            if (!any && !done2 && seen && ndone == 0) ngap++;
            if (done2) ndone++;
            if (mode == 2 && any && waitc >= 2 && waitc <= 4) begin
                check("early_col_stb", 64'(cstb2), 64'd0);
                check("held_row_stb", 64'(rstb2), 64'd1);
                check("held_idx", {62'd0, ridx2, cidx2}, {62'd0, ri0, ci0});
            end
            if (ndone > 0) begin
                in_stb2 = 1'b0; rack2 = 1'b0; cack2 = 1'b0;
            end else begin
                in_stb2 = 1'($urandom_range(0, 1));
                in_data2 = $urandom;
                case (mode)
                    1: begin rack2 = any && waitc == 2; cack2 = any && waitc == 2; end
                    2: begin cack2 = any && waitc == 1; rack2 = any && waitc == 4; end
                    default: begin
                        rack2 = 1'($urandom_range(0, 1));
                        cack2 = 1'($urandom_range(0, 1));
                    end
                endcase
            end
            prev_any = any;
        end
        check("done_count", 64'(ndone), 64'd1);
        check("pair_count", 64'(seq.size()), 64'd4);
        for (int k = 0; k < seq.size(); k++) check("pair_order", 64'(seq[k]), 64'(k));
        check("advance_gaps", 64'(ngap), 64'd3);
    endtask

    initial begin
        logic [31:0] wa [8];
        logic [31:0] wr [8];
        int g;
        wa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        rst = 1'b0;
        in_stb2 = 1'b0; in_data2 = 32'd0; rack2 = 1'b0; cack2 = 1'b0;
        in_stb1 = 1'b0; in_data1 = 32'd0; rack1 = 1'b0; cack1 = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(in_ack2), 64'd0);
        check("rst_stbs", {62'd0, rstb2, cstb2}, 64'd0);
        check("rst_idx_done", {61'd0, ridx2, cidx2, done2}, 64'd0);
        check("rst_n1", {60'd0, in_ack1, rstb1, cstb1, done1}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ack_after_reset", 64'(in_ack2), 64'd1);

        load2(wa, 8, 1'b0);
        serve(1, 1'b1);
        load2(wa, 8, 1'b1);
        serve(2, 1'b1);
        for (int r = 0; r < 3; r++) begin
            foreach (wr[k]) wr[k] = $urandom;
            load2(wr, 8, 1'b1);
            serve(0, 1'b0);
        end

        // reset after five words, then a full reload from A[0][0]
        foreach (wr[k]) wr[k] = $urandom;
        load2(wr, 5, 1'b1);
        @(negedge clk);
        in_stb2 = 1'b0; rack2 = 1'b0; cack2 = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midload_rst", {59'd0, in_ack2, rstb2, cstb2, done2, ridx2}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        load2(wa, 8, 1'b1);
        serve(0, 1'b1);

        // reset while a pair is presented
        load2(wa, 8, 1'b0);
        @(negedge clk);
        in_stb2 = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midissue_rst", {61'd0, rstb2, cstb2, in_ack2}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        foreach (wr[k]) wr[k] = $urandom;
        load2(wr, 8, 1'b1);
        serve(0, 1'b0);

        // N=1 instance
        @(negedge clk);
        g = 0;
        while (!in_ack1 && g < 20) begin @(negedge clk); g++; end
        check("n1_ack", 64'(in_ack1), 64'd1);
        in_stb1 = 1'b1; in_data1 = 32'h3F800000;
        @(negedge clk);
        in_data1 = 32'h40000000;
        @(negedge clk);
        in_stb1 = 1'b0; in_data1 = 32'hDEADBEEF;
        check("n1_row", 64'(row1), 64'h3F800000);
        check("n1_column", 64'(col1), 64'h40000000);
        check("n1_stbs_ack", {61'd0, rstb1, cstb1, in_ack1}, 64'b110);
        check("n1_idx_done", {61'd0, ridx1, cidx1, done1}, 64'd0);
        rack1 = 1'b1; cack1 = 1'b1;
        @(negedge clk);
        rack1 = 1'b0; cack1 = 1'b0;
        check("n1_done", {60'd0, rstb1, cstb1, done1, in_ack1}, 64'b0010);
        @(negedge clk);
        check("n1_reload", {62'd0, done1, in_ack1}, 64'b01);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_operand_feeder.md
MATRIX_OPERAND_FEEDER -- requirements
Module: matrix_operand_feeder

Interface
REQ-001 The block SHALL have parameter number_of_elements, default 4, meaning N (matrix dimension, N >= 1).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port in_data  input  32  serial operand word (IEEE-754 single).
REQ-005 The block SHALL have port in_i_stb  input  1  in_data valid.
REQ-006 The block SHALL have port in_i_ack  output  1  feeder ready; a word transfers on an edge where in_i_stb and in_i_ack are both high.
REQ-007 The block SHALL have port row  output  32*N  row i of A; element k at bits [32k+31:32k].
REQ-008 The block SHALL have port column  output  32*N  column j of B; element k (B[k][j]) at bits [32k+31:32k].
REQ-009 The block SHALL have ports row_o_stb and column_o_stb  output  1 each  row/column valid.
REQ-010 The block SHALL have ports row_o_ack and column_o_ack  input  1 each  downstream acceptance.
REQ-011 The block SHALL have ports row_idx and col_idx  output  clog2(N) (min 1) each  indices i, j of the presented pair.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after the last pair is acknowledged.

Function
REQ-013 The FSM SHALL have states LOAD, ISSUE, ADVANCE and DONE; LOAD is entered from reset.
REQ-014 In LOAD, in_i_ack SHALL be high; it accepts 2*N*N words: A row-major, then B row-major. The word counter advances only on a transfer.
REQ-015 On the edge that accepts the final word, the FSM SHALL go to ISSUE and drop in_i_ack. row_o_stb and column_o_stb SHALL be high from the next cycle with i=j=0.
REQ-016 In ISSUE, row, column, row_idx and col_idx SHALL be held stable.
REQ-017 Each strobe SHALL deassert on the edge after its own ack is sampled high; row and column acks may arrive in the same or different cycles.
REQ-018 An ack sampled while its strobe is low SHALL be ignored.
REQ-019 When both sides are acknowledged, the FSM SHALL go to ADVANCE for exactly one cycle with both strobes low. It SHALL increment j (wrapping to 0 and incrementing i at j=N-1) and return to ISSUE with both strobes high.
REQ-020 Pairs SHALL be issued in order (0,0),(0,1)...(N-1,N-1); N*N pairs total.
REQ-021 After the pair (N-1,N-1) is acknowledged, the FSM SHALL go to DONE instead of ADVANCE; done SHALL be high for one cycle; the next state SHALL be LOAD with counters zeroed.
REQ-022 in_i_stb outside LOAD SHALL be ignored (in_i_ack low, storage unchanged).
REQ-023 For N=1, one pair SHALL be issued, then done.

Reset
REQ-024 While rst=0: in_i_ack=0, row_o_stb=0, column_o_stb=0, done=0, row_idx=0, col_idx=0, counters=0, state=LOAD.
REQ-025 in_i_ack SHALL rise on the first edge after rst deasserts.
REQ-026 Reset mid-load or mid-issue SHALL discard all progress; storage contents are don't-care, and no strobe glitches are permitted.

Structure
REQ-027 word_width=32 and the state encodings SHALL live in a shared package used with inner_product.
REQ-028 Operand storage SHALL be one sub-module, matrix_bank: N*N word registers with a serial write port and row/column read muxes. The feeder SHALL instantiate it twice (A, B).

Verification
REQ-029 Scenario 1: N=2; load A=[3F800000,40000000;40400000,40800000] and B=identity [3F800000,0;0,3F800000]. The first pair SHALL be row={40000000,3F800000}, column={00000000,3F800000}, idx (0,0).
REQ-030 Scenario 2: same load with acks returned simultaneously two cycles after each strobe. The bench SHALL see pairs (0,0),(0,1),(1,0),(1,1), one ADVANCE gap between each, then exactly one done pulse.
REQ-031 Scenario 3: column_o_ack 3 cycles before row_o_ack. column_o_stb SHALL drop alone and the pair SHALL not advance until row_o_ack.
REQ-032 Scenario 4: in_i_stb toggled randomly during load. Exactly 8 words SHALL be stored; in_i_stb held during ISSUE SHALL not alter row/column.
REQ-033 Scenario 5: rst pulsed low after 5 words loaded. All outputs SHALL go to reset values immediately; the subsequent full load SHALL restart from A[0][0].
REQ-034 Scenario 6: N=1, load 3F800000 and 40000000. One pair row=3F800000, column=40000000 SHALL be issued, then done, then in_i_ack high again.
